slow_unpacker: RTL and testbench

Read-side counterpart of the slow-channel packer. It fetches 12-bit orbital words from the orbit RAM read port and re-emits each one as an 18-byte strobed slow frame. Bytes 0–15 are filler; bytes 16–17 carry the 10-bit payload. It sits between the orbit RAM and the slow-frame byte link, and follows the same SW-driven bank restart as the write side.

---
 rtl/slow_link_pkg.sv | 36 +++
 rtl/slow_unpacker_if.sv | 34 +++
 rtl/slow_sw_sync.sv | 33 +++
 rtl/slow_unpacker.sv | 140 ++++++++++++++
 tb/tb_slow_unpacker.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/slow_link_pkg.sv
// Shared definitions for the slow-channel packer and unpacker.
// Holds the frame geometry, the FSM state encoding and the layout of the
// 12-bit orbital word (flag bits 11 and 0 around a 10-bit payload in 10:1).
package slow_link_pkg;

    localparam int FRAME_LEN = 18;
    localparam int IDX_W     = $clog2(FRAME_LEN);

    localparam logic [IDX_W-1:0] PAYLOAD_LO_IDX = IDX_W'(16);
    localparam logic [IDX_W-1:0] PAYLOAD_HI_IDX = IDX_W'(17);

    localparam int WORD_W      = 12;
    localparam int PAYLOAD_W   = 10;
    localparam int FLAG_HI_BIT = 11;
    localparam int FLAG_LO_BIT = 0;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_WAITRD  = 3'd2,
        ST_LATCH   = 3'd3,
        ST_SEND_HI = 3'd4,
        ST_SEND_LO = 3'd5,
        ST_DONE    = 3'd6
    } slow_state_e;

    // A word is malformed when either framing flag is set.
    function automatic logic word_fmt_err(input logic [WORD_W-1:0] w);
        return w[FLAG_HI_BIT] | w[FLAG_LO_BIT];
    endfunction

    function automatic logic [PAYLOAD_W-1:0] word_payload(input logic [WORD_W-1:0] w);
        return w[PAYLOAD_W:1];
    endfunction

endpackage

// File: rtl/slow_unpacker_if.sv
// Bus bundle between the orbit RAM read port / slow-frame byte link and the
// unpacker.
//   req, iWord           : into the unpacker (frame request, RAM read data)
//   rdAddr, RE           : RAM read address and one-cycle read enable
//   oData, strob         : frame byte and its strobe
//   busy, frmDone,
//   fmtErr, test         : status pulses / levels
// master = unpacker side, slave = RAM/link/environment side.
interface slow_unpacker_if
    import slow_link_pkg::*;
#(
    parameter int ADDR_W = 11
);
    logic              req;
    logic [WORD_W-1:0] iWord;
    logic [ADDR_W-1:0] rdAddr;
    logic              RE;
    logic [7:0]        oData;
    logic              strob;
    logic              busy;
    logic              frmDone;
    logic              fmtErr;
    logic              test;

    modport master (
        input  req, iWord,
        output rdAddr, RE, oData, strob, busy, frmDone, fmtErr, test
    );

    modport slave (
        output req, iWord,
        input  rdAddr, RE, oData, strob, busy, frmDone, fmtErr, test
    );
endinterface

// File: rtl/slow_sw_sync.sv
// Two-flop synchroniser for the asynchronous bank-switch input followed by an
// edge detector. Emits a registered one-cycle pulse on every synchronised
// edge (either direction), three clocks after the input changes.
//   clk, rst : clock, synchronous active-high reset
//   async_i  : raw SW input
//   pulse_o  : one-cycle edge pulse
module slow_sw_sync (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic pulse_o
);
    logic sync1_q;
    logic sync2_q;
    logic old_q;
    logic pulse_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            old_q   <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync1_q <= async_i;
            sync2_q <= sync1_q;
            old_q   <= sync2_q;
            pulse_q <= sync2_q ^ old_q;
        end
    end

    assign pulse_o = pulse_q;
endmodule

// File: rtl/slow_unpacker.sv
// Fetches 12-bit orbital words from the orbit RAM and re-emits each as an
// 18-byte strobed slow frame: 16 filler bytes, then payload[7:0], then
// {6'b0, payload[9:8]}. A synchronised SW edge restarts the bank at
// START_ADDR and aborts any frame in flight.
//   clk, rst : clock, synchronous active-high reset
//   SW       : asynchronous bank switch
//   bus      : RAM read port, byte link and status (see slow_unpacker_if)
//
// state      | meaning
// -----------+-------------------------------------------------
// ST_IDLE    | waiting for req
// ST_FETCH   | RE pulse, rdAddr = address pointer
// ST_WAITRD  | RAM read latency
// ST_LATCH   | capture iWord, flag check, byte index cleared
// ST_SEND_HI | current byte on oData, strob high STROB_HI cycles
// ST_SEND_LO | strob low STROB_LO cycles, then next byte or done
// ST_DONE    | frmDone pulse, pointer advance with wrap
module slow_unpacker
    import slow_link_pkg::*;
#(
    parameter int                ADDR_W     = 11,
    parameter logic [ADDR_W-1:0] START_ADDR = 11'd1,
    parameter logic [ADDR_W-1:0] LAST_ADDR  = 11'd2047,
    parameter int                STROB_HI   = 4,
    parameter int                STROB_LO   = 4,
    parameter logic [7:0]        FILL       = 8'h00
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             SW,
    slow_unpacker_if.master  bus
);
    slow_state_e          state_q, state_d;
    logic [ADDR_W-1:0]    addr_ptr_q, addr_ptr_d;
    logic [PAYLOAD_W-1:0] payload_q, payload_d;
    logic [IDX_W-1:0]     byte_idx_q, byte_idx_d;
    logic [7:0]           cnt_q, cnt_d;
    logic [7:0]           data_q, data_d;
    logic                 sw_pulse;

    slow_sw_sync u_sw_sync (
        .clk     (clk),
        .rst     (rst),
        .async_i (SW),
        .pulse_o (sw_pulse)
    );

    function automatic logic [7:0] frame_byte(input logic [IDX_W-1:0]     idx,
                                              input logic [PAYLOAD_W-1:0] pl);
        if (idx == PAYLOAD_LO_IDX)      return pl[7:0];
        else if (idx == PAYLOAD_HI_IDX) return {6'b0, pl[9:8]};
        else                            return FILL;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            addr_ptr_q <= START_ADDR;
            payload_q  <= '0;
            byte_idx_q <= '0;
            cnt_q      <= '0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            addr_ptr_q <= addr_ptr_d;
            payload_q  <= payload_d;
            byte_idx_q <= byte_idx_d;
            cnt_q      <= cnt_d;
            data_q     <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:    if (bus.req) state_d = ST_FETCH;
            ST_FETCH:   state_d = ST_WAITRD;
            ST_WAITRD:  state_d = ST_LATCH;
            ST_LATCH:   state_d = ST_SEND_HI;
            ST_SEND_HI: if (cnt_q == 8'd0) state_d = ST_SEND_LO;
            ST_SEND_LO: begin
                if (cnt_q == 8'd0)
                    state_d = (byte_idx_q == PAYLOAD_HI_IDX) ? ST_DONE : ST_SEND_HI;
            end
            ST_DONE:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
        // A bank restart wins over every other transition.
        if (sw_pulse) state_d = ST_IDLE;
    end

    always_comb begin
        addr_ptr_d = addr_ptr_q;
        payload_d  = payload_q;
        byte_idx_d = byte_idx_q;
        cnt_d      = (cnt_q != 8'd0) ? cnt_q - 8'd1 : cnt_q;
        data_d     = data_q;

        unique case (state_q)
            ST_LATCH: begin
                payload_d  = word_payload(bus.iWord);
                byte_idx_d = '0;
            end
            ST_SEND_LO: begin
                if (cnt_q == 8'd0 && byte_idx_q != PAYLOAD_HI_IDX)
                    byte_idx_d = byte_idx_q + IDX_W'(1);
            end
            ST_DONE: begin
                addr_ptr_d = (addr_ptr_q == LAST_ADDR) ? START_ADDR
                                                       : addr_ptr_q + ADDR_W'(1);
            end
            default: ;
        endcase

        // oData only moves on entry to the high phase, so it is stable for
        // the whole byte period seen by the link.
        if (state_d == ST_SEND_HI && state_q != ST_SEND_HI) begin
            cnt_d  = 8'(STROB_HI - 1);
            data_d = frame_byte(byte_idx_d, payload_d);
        end
        if (state_d == ST_SEND_LO && state_q != ST_SEND_LO)
            cnt_d = 8'(STROB_LO - 1);

        if (sw_pulse) begin
            addr_ptr_d = START_ADDR;
            byte_idx_d = '0;
        end
    end

    always_comb begin
        bus.RE      = (state_q == ST_FETCH);
        bus.rdAddr  = (state_q == ST_FETCH) ? addr_ptr_q : '0;
        bus.strob   = (state_q == ST_SEND_HI);
        bus.busy    = (state_q != ST_IDLE);
        bus.frmDone = (state_q == ST_DONE) && !sw_pulse;
        bus.fmtErr  = (state_q == ST_LATCH) && word_fmt_err(bus.iWord);
        bus.test    = sw_pulse;
        bus.oData   = data_q;
    end
endmodule

// File: tb/tb_slow_unpacker.sv
module tb_slow_unpacker;
    localparam int          ADDR_W   = 11;
    localparam logic [10:0] START    = 11'd1;
    localparam logic [10:0] LAST     = 11'd3;
    localparam int          SHI      = 4;
    localparam int          SLO      = 4;
    localparam int          BYTE_T   = SHI + SLO;
    localparam int          FIRST_HI = 4;
    localparam int          DONE_OFF = FIRST_HI + 18 * BYTE_T;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic SW  = 1'b0;
    always #5 clk = ~clk;

    slow_unpacker_if #(.ADDR_W(ADDR_W)) bus();

    slow_unpacker #(
        .ADDR_W(ADDR_W), .START_ADDR(START), .LAST_ADDR(LAST),
        .STROB_HI(SHI), .STROB_LO(SLO), .FILL(8'h00)
    ) dut (
        .clk(clk), .rst(rst), .SW(SW), .bus(bus)
    );

    // Orbit RAM: registered read, data held until the next RE.
    logic [11:0] mem [0:2047];
    logic [11:0] ram_q = '0;
    always @(posedge clk) if (bus.RE === 1'b1) ram_q <= mem[bus.rdAddr];
    assign bus.iWord = ram_q;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] mbyte(input int b, input logic [11:0] w);
        if (b < 16) return 8'h00;
        if (b == 16) return w[8:1];
        return {6'b0, w[10:9]};
    endfunction

    // ---------------- behavioural model + per-cycle compare ----------------
    // A frame is described by the cycle its req was accepted (s) and offsets
    // from it; SW edges appear 3 cycles after the input changes.
    bit          mv = 0, act = 0;
    int          cyc = 0, s = 0, o = 0;
    logic [10:0] ptr = START, fa = '0;
    logic [11:0] fw = '0;
    logic [7:0]  od = '0;
    bit          h1 = 0, h2 = 0, h3 = 0, h4 = 0;
    logic        e_test, e_busy, e_re, e_fmt, e_str, e_done;

    always @(negedge clk) begin
        e_test = h3 ^ h4;
        e_busy = 0; e_re = 0; e_fmt = 0; e_str = 0; e_done = 0;
        if (mv) begin
            if (act) begin
                o      = cyc - s;
                e_busy = 1;
                e_re   = (o == 1);
                e_fmt  = (o == 3) && (fw[11] | fw[0]);
                e_str  = (o >= FIRST_HI) && (o < DONE_OFF) && (((o - FIRST_HI) % BYTE_T) < SHI);
                if (o >= FIRST_HI && o < DONE_OFF) od = mbyte((o - FIRST_HI) / BYTE_T, fw);
                e_done = (o == DONE_OFF) && !e_test;
            end
            chk("test",    bus.test,    e_test);
            chk("busy",    bus.busy,    e_busy);
            chk("RE",      bus.RE,      e_re);
            chk("fmtErr",  bus.fmtErr,  e_fmt);
            chk("strob",   bus.strob,   e_str);
            chk("frmDone", bus.frmDone, e_done);
            chk("oData",   bus.oData,   od);
            if (e_re) chk("rdAddr", bus.rdAddr, fa);
        end
        if (rst) begin
            act = 0; ptr = START; od = '0;
            h1 = 0; h2 = 0; h3 = 0; h4 = 0;
            mv = 1;
        end else if (mv) begin
            if (e_test) begin
                ptr = START; act = 0;
            end else if (act && (cyc - s) == DONE_OFF) begin
                act = 0;
                ptr = (ptr == LAST) ? START : ptr + 11'd1;
            end else if (!act && bus.req) begin
                act = 1; s = cyc; fa = ptr; fw = mem[ptr];
            end
            h4 = h3; h3 = h2; h2 = h1; h1 = SW;
        end
        cyc++;
    end

    // ---------------- directed stimulus with literal expectations ----------------
    task automatic nxt();
        @(posedge clk);
        #2;
    endtask

    logic [7:0] cap_b [0:17];
    int cap_n, cap_done, cap_fmt, cap_re, cap_rise, hi_bad, lo_bad;

    task automatic run_frame();
        bit prev;
        int run;
        cap_n = 0; cap_done = -1; cap_fmt = -1; cap_re = -1; cap_rise = -1;
        hi_bad = 0; lo_bad = 0; prev = 0; run = 0;
        nxt();
        bus.req = 1'b1;
        nxt();
        bus.req = 1'b0;
        for (int off = 1; off < 400; off++) begin
            if (bus.frmDone) begin
                cap_done = off;
                if (run != SLO) lo_bad++;
                break;
            end
            if (bus.RE) cap_re = int'(bus.rdAddr);
            if (bus.fmtErr) cap_fmt = off;
            if (bus.strob != prev) begin
                if (prev && run != SHI) hi_bad++;
                if (!prev && cap_n > 0 && run != SLO) lo_bad++;
                if (bus.strob) begin
                    if (cap_n == 0) cap_rise = off;
                    if (cap_n < 18) cap_b[cap_n] = bus.oData;
                    cap_n++;
                end
                run = 0;
            end
            run++;
            prev = bus.strob;
            nxt();
        end
        if (cap_done < 0) chk("frame_timeout", 0, 1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},    bus.busy,    0);
        chk({tag, "_strob"},   bus.strob,   0);
        chk({tag, "_RE"},      bus.RE,      0);
        chk({tag, "_rdAddr"},  bus.rdAddr,  0);
        chk({tag, "_oData"},   bus.oData,   0);
        chk({tag, "_frmDone"}, bus.frmDone, 0);
        chk({tag, "_fmtErr"},  bus.fmtErr,  0);
        chk({tag, "_test"},    bus.test,    0);
    endtask

    initial begin
        int re_addr [4];
        int re_cyc [4];
        int nre, dbl, lat, dseen, n;
        bit re_prev;

        for (int i = 0; i < 2048; i++) mem[i] = 12'($urandom);
        mem[1] = 12'h2AA;
        mem[2] = 12'h801;
        bus.req = 1'b0;

        repeat (3) @(posedge clk);
        #2;
        chk_all_zero("reset");
        rst = 1'b0;

        // Frame at address 1: payload 0x155.
        run_frame();
        chk("A_done_cycle", cap_done, DONE_OFF);
        chk("A_nbytes", cap_n, 18);
        chk("A_first_hi", cap_rise, FIRST_HI);
        chk("A_byte0", cap_b[0], 8'h00);
        chk("A_byte15", cap_b[15], 8'h00);
        chk("A_byte16", cap_b[16], 8'h55);
        chk("A_byte17", cap_b[17], 8'h01);
        chk("A_hi_len", hi_bad, 0);
        chk("A_lo_len", lo_bad, 0);
        chk("A_addr", cap_re, 1);
        chk("A_fmt", cap_fmt, -1);

        // Frame at address 2: both flags set, payload zero.
        run_frame();
        chk("B_addr", cap_re, 2);
        chk("B_fmt_cycle", cap_fmt, 3);
        chk("B_byte16", cap_b[16], 8'h00);
        chk("B_byte17", cap_b[17], 8'h00);
        chk("B_done_cycle", cap_done, DONE_OFF);

        // req held high: frames at 3, 1, 2, 3 (wrap never hits 0).
        nxt();
        bus.req = 1'b1;
        nre = 0; dbl = 0; re_prev = 0;
        for (int k = 0; k < 800 && nre < 4; k++) begin
            nxt();
            if (bus.RE) begin
                if (re_prev) dbl++;
                re_addr[nre] = int'(bus.rdAddr);
                re_cyc[nre]  = k;
                nre++;
            end
            re_prev = bus.RE;
        end
        bus.req = 1'b0;
        chk("b2b_count", nre, 4);
        chk("b2b_addr0", re_addr[0], 3);
        chk("b2b_addr1", re_addr[1], 1);
        chk("b2b_addr2", re_addr[2], 2);
        chk("b2b_addr3", re_addr[3], 3);
        chk("b2b_gap", re_cyc[1] - re_cyc[0], DONE_OFF + 1);
        chk("b2b_re_single", dbl, 0);
        n = 0;
        while (!bus.frmDone && n < 300) begin nxt(); n++; end
        chk("b2b_last_done", bus.frmDone, 1);

        // Advance pointer to 2, then reset during a high phase.
        run_frame();
        chk("C_addr", cap_re, 1);
        nxt();
        bus.req = 1'b1;
        nxt();
        bus.req = 1'b0;
        n = 0;
        while (!bus.strob && n < 20) begin nxt(); n++; end
        chk("rst_reach_hi", bus.strob, 1);
        rst = 1'b1;
        nxt();
        rst = 1'b0;
        chk_all_zero("midrst");
        run_frame();
        chk("after_rst_addr", cap_re, 1);

        // SW edge during byte 9 (pointer is 2 here).
        nxt();
        bus.req = 1'b1;
        nxt();
        bus.req = 1'b0;
        repeat (FIRST_HI + 9 * BYTE_T + 1) nxt();
        chk("sw_in_byte9", bus.strob, 1);
        SW = 1'b1;
        lat = -1;
        for (int k = 1; k <= 10; k++) begin
            nxt();
            if (bus.test) begin lat = k; break; end
        end
        chk("sw_latency", lat, 3);
        nxt();
        chk("sw_busy", bus.busy, 0);
        chk("sw_strob", bus.strob, 0);
        dseen = 0;
        repeat (200) begin
            if (bus.frmDone) dseen++;
            nxt();
        end
        chk("sw_no_done", dseen, 0);
        run_frame();
        chk("after_sw_addr", cap_re, 1);

        // Randomized traffic, SW toggles and occasional resets.
        for (int k = 0; k < 8000; k++) begin
            nxt();
            bus.req = ($urandom_range(0, 99) < 30);
            if ($urandom_range(0, 399) == 0) SW = ~SW;
            rst = ($urandom_range(0, 1499) == 0);
        end
        rst = 1'b0;
        bus.req = 1'b0;
        repeat (4) nxt();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
